accum_window_sampler: RTL

Downstream consumer of the 16-bit feedback accumulator. It samples the running sum on every enabled cycle and closes a window every `decim` enabled cycles. For each window it emits the wrap-safe difference between the closing and opening accumulator values, which is the sum of inputs over that window. Results are buffered in a small FIFO with a valid/ready output to the next stage.

---
 rtl/accum_pkg.sv | 17 +
 rtl/accum_window_sampler_if.sv | 12 +
 rtl/accum_fifo.sv | 47 ++++
 rtl/accum_window_sampler.sv | 108 ++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types for the accumulator window sampler: FSM states and the
// FIFO entry layout (first-window flag above the window sum).
package accum_pkg;

   localparam int ACC_W = 16;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   typedef struct packed {
      logic             first;
      logic [ACC_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/accum_window_sampler_if.sv
// Valid/ready result stream carrying one window sum per transfer.
interface accum_window_sampler_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] m_data;
   logic             m_first;
   logic             m_valid;
   logic             m_ready;

   modport master (output m_data, output m_first, output m_valid, input m_ready);
   modport slave  (input m_data, input m_first, input m_valid, output m_ready);
endinterface

// File: rtl/accum_fifo.sv
// Synchronous FIFO addressed by read/write pointers that carry one extra
// wrap bit. A push into a full FIFO is accepted when a pop happens in the same cycle.
module accum_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  level_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic         pop_ok, push_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         // When full, the written slot is the one being popped this cycle.
         if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/accum_window_sampler.sv
// Samples the running accumulator on enabled cycles and emits, once every
// decim samples, the modular difference between the closing and opening values.
module accum_window_sampler
   import accum_pkg::*;
#(
   parameter int WIDTH   = ACC_W,
   parameter int DEPTH   = 4,
   parameter int DECIM_W = 8,
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     acc_in,
   input  logic                 en,
   input  logic                 acc_clr,
   input  logic [DECIM_W-1:0]   decim,
   accum_window_sampler_if.master m,
   output logic                 ovf,
   output logic [LVL_W-1:0]     level
);

   // state    | meaning
   // ST_PRIME | waiting for the first enabled sample to latch the base value
   // ST_RUN   | counting samples; close the window when cnt reaches dm1

   state_t             state_q, state_d;
   logic [DECIM_W-1:0] cnt_q, cnt_d, dm1;
   logic [WIDTH-1:0]   base_q, base_d, diff;
   logic               first_q, first_d;
   logic               ovf_q, ovf_d;
   logic               push;
   logic               fifo_full, fifo_empty;
   logic [WIDTH:0]     fifo_dout;

   assign dm1  = (decim == '0) ? '0 : decim - 1'b1;
   assign diff = acc_in - base_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      first_d = first_q;
      ovf_d   = ovf_q;
      push    = 1'b0;
      if (acc_clr) begin
         state_d = ST_PRIME;
         cnt_d   = '0;
         first_d = 1'b0;
         ovf_d   = 1'b0;
      end else if (en) begin
         case (state_q)
            ST_PRIME: begin
               base_d  = acc_in;
               cnt_d   = '0;
               first_d = 1'b1;
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (cnt_q >= dm1) begin
                  push    = 1'b1;
                  base_d  = acc_in;
                  cnt_d   = '0;
                  first_d = 1'b0;
                  // Dropped window: base still advances so the next sum stays correct.
                  if (fifo_full && !(m.m_valid && m.m_ready)) ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_PRIME;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_PRIME;
         cnt_q   <= '0;
         base_q  <= '0;
         first_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         first_q <= first_d;
         ovf_q   <= ovf_d;
      end
   end

   accum_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   ({first_q, diff}),
      .pop_i   (m.m_ready),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   assign m.m_valid = !fifo_empty;
   assign m.m_first = fifo_dout[WIDTH];
   assign m.m_data  = fifo_dout[WIDTH-1:0];
   assign ovf       = ovf_q;

endmodule
